// File: rtl/nrd_pkg.sv
// nrd_pkg: shared types, default sizes and round-robin grant helper for the
// shared non-restoring divider controller.
package nrd_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIX, RESP} state_t;

    localparam int DEF_W = 4;
    localparam int DEF_N = 4;

    // First set bit of valid at or after (ptr+1) mod n, wrapping; -1 when none.
    // Walking k downwards lets the closest candidate win the last assignment.
    function automatic int rr_next(input logic [31:0] valid, input int n, input int ptr);
        rr_next = -1;
        for (int k = n; k >= 1; k--)
            if (valid[5'((ptr + k) % n)]) rr_next = (ptr + k) % n;
    endfunction

endpackage

// File: rtl/nrd_step.sv
// nrd_step: one combinational non-restoring division iteration
// (shift A:Q left, add or subtract the divisor by the sign of A).
module nrd_step
    import nrd_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W:0]   a_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] m_i,
    output logic [W:0]   a_o,
    output logic [W-1:0] q_o
);

    logic [W:0] a_sh;

    assign a_sh = {a_i[W-1:0], q_i[W-1]};
    assign a_o  = a_i[W] ? a_sh + {1'b0, m_i} : a_sh - {1'b0, m_i};
    assign q_o  = {q_i[W-2:0], ~a_o[W]};

endmodule

// File: rtl/nrd_share_ctrl.sv
// nrd_share_ctrl: round-robin shared iterative non-restoring unsigned divider;
// one division in flight, result returned on a single valid/ready channel.
module nrd_share_ctrl
    import nrd_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int N   = DEF_N,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_dividend,
    input  logic [N*W-1:0]   req_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [W-1:0]     rsp_quot,
    output logic [W-1:0]     rsp_rem,
    output logic             rsp_dbz,
    output logic             busy
);

    localparam int CW = $clog2(W) + 1;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d, id_q, id_d, rid_q, rid_d;
    logic [W:0]     a_q, a_d, a_step, a_fix;
    logic [W-1:0]   q_q, q_d, m_q, m_d, q_step, quot_q, quot_d, rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dbz_q, dbz_d, found;
    logic [IDW-1:0] gnt;
    logic [W-1:0]   sel_dvd, sel_dvs;
    int             g_int;

    assign g_int   = rr_next(32'(req_valid), N, int'(rr_q));
    assign found   = g_int >= 0;
    assign gnt     = IDW'(g_int);
    assign sel_dvd = req_dividend[gnt*W +: W];
    assign sel_dvs = req_divisor[gnt*W +: W];
    assign a_fix   = a_q[W] ? a_q + {1'b0, m_q} : a_q;

    nrd_step #(.W(W)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (a_step),
        .q_o (q_step)
    );

    // Grant is only offered while idle and out of reset.
    assign req_ready = (n_rst && state_q == IDLE && found) ? N'(1) << gnt : '0;
    assign rsp_valid = state_q == RESP;
    assign busy      = state_q != IDLE;
    assign rsp_id    = rid_q;
    assign rsp_quot  = quot_q;
    assign rsp_rem   = rem_q;
    assign rsp_dbz   = dbz_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        rid_d   = rid_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (found) begin
                m_d   = sel_dvs;
                q_d   = sel_dvd;
                a_d   = '0;
                cnt_d = '0;
                id_d  = gnt;
                rr_d  = gnt;
                state_d = RUN;
                if (sel_dvs == '0) begin
                    state_d = RESP;
                    quot_d  = '1;
                    rem_d   = sel_dvd;
                    rid_d   = gnt;
                    dbz_d   = 1'b1;
                end
            end
            RUN: begin
                a_d   = a_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) state_d = FIX;
            end
            FIX: begin
                a_d     = a_fix;
                quot_d  = q_q;
                rem_d   = a_fix[W-1:0];
                rid_d   = id_q;
                dbz_d   = 1'b0;
                state_d = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            rr_q    <= IDW'(N - 1);
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            rid_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            rid_q   <= rid_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_nrd_share_ctrl.sv
// tb_nrd_share_ctrl: table-driven and scoreboard bench for the shared
// round-robin non-restoring divider controller.
module tb_nrd_share_ctrl;

    localparam int W = 4;
    localparam int N = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_dividend = '0;
    logic [N*W-1:0]   req_divisor = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_quot, rsp_rem;
    logic             rsp_dbz, busy;

    typedef struct { int id; int quot; int rem; int dbz; } exp_t;
    typedef struct { int id; int dvd; int dvs; int quot; int rem; int dbz; } vec_t;

    exp_t sb[$];
    vec_t vt[7];
    int   compared = 0;
    int   mismatched = 0;
    int   cdvd[N] = '{14, 7, 10, 12};
    int   cdvs[N] = '{3, 2, 4, 5};

    nrd_share_ctrl #(.W(W), .N(N)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_quot     (rsp_quot),
        .rsp_rem      (rsp_rem),
        .rsp_dbz      (rsp_dbz),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a transfer happens on the next edge when valid & ready at negedge.
    always @(negedge clk) begin
        if (n_rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", int'(rsp_id), e.id);
                chk("rsp_quot", int'(rsp_quot), e.quot);
                chk("rsp_rem", int'(rsp_rem), e.rem);
                chk("rsp_dbz", int'(rsp_dbz), e.dbz);
            end
        end
    end

    task automatic push_exp(input int id, input int q, input int r, input int z);
        exp_t e;
        e.id = id; e.quot = q; e.rem = r; e.dbz = z;
        sb.push_back(e);
    endtask

    task automatic drive(input int id, input int dvd, input int dvs);
        req_valid[id] = 1'b1;
        req_dividend[id*W +: W] = W'(dvd);
        req_divisor[id*W +: W] = W'(dvs);
    endtask

    // Issue one request, check grant and response latency; returns at the
    // negedge where rsp_valid is first seen high.
    task automatic issue(input int id, input int dvd, input int dvs,
                         input int q, input int r, input int z);
        int n;
        @(posedge clk); #1;
        drive(id, dvd, dvs);
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            chk("grant_timeout", 0, 1);
            req_valid[id] = 1'b0;
            return;
        end
        push_exp(id, q, r, z);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk("latency", n, z ? 1 : W + 2);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("idle_timeout", 0, 1);
    endtask

    task automatic contend(input logic [N-1:0] mask, input int ord[3], input int cnt);
        int n, g;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) if (mask[i]) drive(i, cdvd[i], cdvs[i]);
        @(negedge clk);
        for (int k = 0; k < cnt; k++) begin
            n = 0;
            while (req_ready == '0 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) begin
                chk("contend_timeout", 0, 1);
                req_valid = '0;
                return;
            end
            chk("grant_onehot", $countones(req_ready), 1);
            g = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
            chk("grant_order", g, ord[k]);
            push_exp(g, cdvd[g] / cdvs[g], cdvd[g] % cdvs[g], 0);
            @(posedge clk); #1;
            req_valid[g] = 1'b0;
            @(negedge clk);
            wait_idle();
        end
    endtask

    initial begin
        vt[0] = '{0, 13, 3, 4, 1, 0};
        vt[1] = '{1, 15, 1, 15, 0, 0};
        vt[2] = '{3, 2, 7, 0, 2, 0};
        vt[3] = '{0, 0, 5, 0, 0, 0};
        vt[4] = '{1, 15, 15, 1, 0, 0};
        vt[5] = '{2, 9, 0, 15, 9, 1};
        vt[6] = '{3, 11, 2, 5, 1, 0};

        #12;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_quot", int'(rsp_quot), 0);
        chk("rst_rsp_rem", int'(rsp_rem), 0);
        chk("rst_rsp_dbz", int'(rsp_dbz), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            issue(vt[i].id, vt[i].dvd, vt[i].dvs, vt[i].quot, vt[i].rem, vt[i].dbz);
            @(negedge clk);
            wait_idle();
        end

        // Contention from a fresh reset: pointer starts at N-1, so 0,1,3.
        @(posedge clk); #1;
        n_rst = 1'b0;
        #2;
        n_rst = 1'b1;
        contend(4'b1011, '{0, 1, 3}, 3);
        contend(4'b0011, '{0, 1, 0}, 2);

        // Backpressure on the response channel.
        rsp_ready = 1'b0;
        issue(0, 13, 3, 4, 1, 0);
        req_valid[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_quot", int'(rsp_quot), 4);
            chk("bp_rem", int'(rsp_rem), 1);
            chk("bp_id", int'(rsp_id), 0);
            chk("bp_busy", int'(busy), 1);
            chk("bp_req_ready", int'(req_ready), 0);
            @(negedge clk);
        end
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", int'(rsp_valid), 0);
        chk("bp_release_busy", int'(busy), 0);

        // Reset during the second RUN iteration abandons the division.
        @(posedge clk); #1;
        drive(3, 11, 2);
        @(negedge clk);
        chk("mid_grant", int'(req_ready), 8);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(rsp_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_quot", int'(rsp_quot), 0);
        chk("mid_rst_rem", int'(rsp_rem), 0);
        chk("mid_rst_req_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            chk("stale_rsp", seen, 0);
        end
        issue(3, 11, 2, 5, 1, 0);
        @(negedge clk);
        wait_idle();

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
